// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: CPU MEM stage (port 0) vs DMA/debug (port 1).
// Contention policy: fixed priority to port 0, or round-robin when DM_ARB_RR_EN is defined.
module dm_arbiter #(
  parameter logic [3:0] TIMEOUT = 4'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [3:0]  be0,
  input  logic [3:0]  be1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        cpu_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_t;

  state_t     state;
  acc_t       a0, a1, sel, acc_q;
  logic       owner;
  logic       win;
  logic [3:0] cnt;

  assign a0 = {we0, addr0, be0, wdata0};
  assign a1 = {we1, addr1, be1, wdata1};

`ifdef DM_ARB_RR_EN
  logic last_owner;
  // Under contention the port that did not win last time goes next.
  always_comb begin
    win = req[1];
    if (req == 2'b11) win = ~last_owner;
  end
`else
  always_comb begin
    win = ~req[0];
  end
`endif

  assign sel = win ? a1 : a0;

  // Grant is decided combinationally in the IDLE cycle so a zero-wait access
  // spans gnt(T), mem_en(T+1), rvalid(T+2).
  always_comb begin
    gnt = 2'b00;
    if (reset && state == IDLE && req != 2'b00) gnt = win ? 2'b10 : 2'b01;
  end

  always_comb begin
    rvalid = 2'b00;
    if (state == DONE) rvalid = owner ? 2'b10 : 2'b01;
  end

  assign cpu_stall = req[0] & ~rvalid[0];

  // Memory side decodes straight from state so reset drops mem_en at once.
  assign mem_en    = (state == BUSY);
  assign mem_we    = mem_en & acc_q.we;
  assign mem_addr  = mem_en ? acc_q.addr  : 32'h0;
  assign mem_wdata = mem_en ? acc_q.wdata : 32'h0;
  assign mem_be    = mem_en ? acc_q.be    : 4'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= 1'b0;
      acc_q <= '0;
      cnt   <= 4'd0;
      rdata <= 32'h0;
      err   <= 1'b0;
`ifdef DM_ARB_RR_EN
      last_owner <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner <= win;
            acc_q <= sel;
            cnt   <= 4'd0;
`ifdef DM_ARB_RR_EN
            last_owner <= win;
`endif
            // Empty byte enable: nothing to access, complete immediately.
            if (sel.be == 4'h0) begin
              rdata <= 32'h0;
              err   <= 1'b0;
              state <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (mem_ready) begin
            rdata <= acc_q.we ? 32'h0 : mem_rdata;
            err   <= 1'b0;
            state <= DONE;
          end else if (cnt == TIMEOUT - 4'd1) begin
            rdata <= 32'h0;
            err   <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized self-checking bench for dm_arbiter, transaction-level reference model.
// Policy expectations follow DM_ARB_RR_EN the same way the design does.
module tb_dm_arbiter;

  localparam logic [3:0] TO = 4'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic        f_we   [2];
  logic [31:0] f_addr [2];
  logic [3:0]  f_be   [2];
  logic [31:0] f_wd   [2];
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        err, cpu_stall, mem_en, mem_we, mem_ready;
  logic [3:0]  mem_be;

  dm_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req),
    .we0(f_we[0]), .we1(f_we[1]), .addr0(f_addr[0]), .addr1(f_addr[1]),
    .be0(f_be[0]), .be1(f_be[1]), .wdata0(f_wd[0]), .wdata1(f_wd[1]),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err), .cpu_stall(cpu_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_err = 0;
  bit [1:0]    pend, act;
  int          last;
  logic [31:0] last_rd;
  logic        last_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input bit [1:0] p);
    if (p == 2'b01) return 0;
    if (p == 2'b10) return 1;
`ifdef DM_ARB_RR_EN
    return (last == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // One complete access from the IDLE grant cycle to the end of the rvalid cycle.
  // lat = BUSY cycle (1-based) in which mem_ready rises; lat > TO means never.
  task automatic serve(input int lat, input logic [31:0] rdv, output int w);
    logic [31:0] erd, e_addr, e_wd;
    logic [3:0]  e_be;
    logic        eerr, e_we, hit;
    w = pick(pend);
    req = pend | act;
    @(negedge clk);
    chk("gnt", gnt, (w == 1) ? 2'b10 : 2'b01);
    chk("stall_gnt", cpu_stall, req[0]);
    chk("hold_rdata", rdata, last_rd);
    chk("hold_err", err, last_err);
    chk("idle_mem_en", mem_en, 1'b0);
    e_we = f_we[w]; e_addr = f_addr[w]; e_be = f_be[w]; e_wd = f_wd[w];
    last = w;
    act = (w == 1) ? 2'b10 : 2'b01;
    pend[w] = 1'b0;
    erd = 32'h0; eerr = 1'b0; hit = 1'b0;
    @(posedge clk); #1;
    req = pend | act;
    if (e_be != 4'h0) begin
      for (int k = 1; k <= int'(TO); k++) begin
        mem_ready = (k == lat);
        mem_rdata = (k == lat) ? rdv : $urandom;
        @(negedge clk);
        chk("mem_en", mem_en, 1'b1);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_be", mem_be, e_be);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("busy_gnt", gnt, 2'b00);
        chk("busy_rvalid", rvalid, 2'b00);
        chk("busy_stall", cpu_stall, req[0]);
        @(posedge clk); #1;
        if (k == lat) begin
          hit = 1'b1;
          erd = e_we ? 32'h0 : rdv;
          break;
        end
      end
      mem_ready = 1'b0;
      if (!hit) eerr = 1'b1;
    end
    @(negedge clk);
    chk("rvalid", rvalid, (w == 1) ? 2'b10 : 2'b01);
    chk("rdata", rdata, erd);
    chk("err", err, eerr);
    chk("done_mem_en", mem_en, 1'b0);
    chk("done_gnt", gnt, 2'b00);
    chk("done_stall", cpu_stall, req[0] & (w != 0));
    last_rd = erd; last_err = eerr; act = 2'b00;
    @(posedge clk); #1;
    req = pend;
  endtask

  task automatic set_port(input int p, input logic we, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
    f_we[p] = we; f_addr[p] = a; f_be[p] = be; f_wd[p] = wd;
  endtask

  initial begin
    int w;
    reset = 1'b0; req = 2'b00; pend = 2'b00; act = 2'b00;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    for (int p = 0; p < 2; p++) set_port(p, 1'b0, 32'h0, 4'h0, 32'h0);
    last = 1; last_rd = 32'h0; last_err = 1'b0;

    #12;
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_rvalid", rvalid, 2'b00);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", err, 1'b0);
    req = 2'b11;
    #1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_stall", cpu_stall, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; req = 2'b00;

    // Continuous contention straight out of reset.
    set_port(0, 1'b0, 32'h100, 4'hF, 32'h0);
    set_port(1, 1'b0, 32'h200, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      pend = 2'b11;
      serve(1, $urandom, w);
`ifdef DM_ARB_RR_EN
      chk("contend_seq", w, i % 2);
`else
      chk("contend_seq", w, 0);
`endif
    end
    pend = 2'b00; req = 2'b00;
    @(posedge clk); #1;

    set_port(0, 1'b0, 32'h10, 4'hF, 32'h0);
    pend = 2'b01; serve(1, 32'hDEADBEEF, w);
    set_port(0, 1'b1, 32'h20, 4'h3, 32'h12345678);
    pend = 2'b01; serve(2, 32'hCAFEF00D, w);
    set_port(1, 1'b1, 32'h30, 4'h0, 32'hA5A5A5A5);
    pend = 2'b10; serve(1, 32'h0, w);
    set_port(0, 1'b0, 32'h40, 4'hF, 32'h0);
    pend = 2'b01; serve(int'(TO) + 1, 32'h11111111, w);
    pend = 2'b01; serve(int'(TO), 32'h22222222, w);

    // Reset in the middle of an access.
    set_port(0, 1'b0, 32'h50, 4'hF, 32'h0);
    set_port(1, 1'b0, 32'h60, 4'hF, 32'h0);
    req = 2'b01;
    @(negedge clk);
    chk("mr_gnt", gnt, 2'b01);
    @(posedge clk); #1;
    req = 2'b11;
    @(negedge clk);
    chk("mr_busy", mem_en, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("mr_mem_en", mem_en, 1'b0);
    chk("mr_rvalid", rvalid, 2'b00);
    repeat (2) begin
      @(negedge clk);
      chk("mr_hold_rvalid", rvalid, 2'b00);
      chk("mr_hold_gnt", gnt, 2'b00);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    last = 1; last_rd = 32'h0; last_err = 1'b0; act = 2'b00;
    pend = 2'b11;
    serve(1, $urandom, w);

    for (int it = 0; it < 150; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 1) == 1)) begin
          pend[p] = 1'b1;
          set_port(p, 1'($urandom), $urandom,
                   ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom);
        end
      end
      if (pend == 2'b00) begin
        pend[0] = 1'b1;
        set_port(0, 1'($urandom), $urandom, 4'($urandom_range(1, 15)), $urandom);
      end
      serve($urandom_range(1, int'(TO) + 1), $urandom, w);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4'd15: maximum BUSY cycles without mem_ready before an access is aborted (legal 1..15).
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 2: access request; bit 0 is the CPU MEM stage, bit 1 is the DMA/debug port.
REQ-005 SHALL have ports we0/we1 (input, 1), addr0/addr1 (input, 32), be0/be1 (input, 4) and wdata0/wdata1 (input, 32): per-port request fields.
REQ-006 SHALL have port gnt, output, 2: one-cycle grant pulse per port.
REQ-007 SHALL have port rvalid, output, 2: one-cycle completion pulse per port.
REQ-008 SHALL have ports rdata (output, 32) and err (output, 1): completion data and timeout flag, both qualified by rvalid.
REQ-009 SHALL have port cpu_stall, output, 1: pipeline freeze for the CPU.
REQ-010 SHALL have ports mem_en, mem_we (output, 1), mem_addr, mem_wdata (output, 32), mem_be (output, 4), mem_rdata (input, 32) and mem_ready (input, 1): the data memory side.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-012 In IDLE, when req is nonzero, SHALL select one winner, pulse gnt[winner] for that cycle, and latch that port's we/addr/be/wdata and owner index.
REQ-013 From IDLE with a winner, SHALL go to BUSY; if the latched be == 4'b0000, SHALL instead go directly to DONE with no mem_en cycle.
REQ-014 In BUSY, SHALL drive mem_en=1 with mem_we/mem_addr/mem_be/mem_wdata from the latched fields; in every other state SHALL drive mem_en=0 and all mem_* outputs to 0.
REQ-015 In BUSY with mem_ready=1, SHALL capture rdata = mem_rdata on reads (rdata = 0 on writes), set err=0, and go to DONE.
REQ-016 SHALL count BUSY cycles in a 4-bit counter cleared on BUSY entry; if the count reaches TIMEOUT without mem_ready, SHALL go to DONE with err=1 and rdata=0.
REQ-017 A mem_ready arriving in the same cycle as the timeout SHALL win: the access completes normally with err=0.
REQ-018 In DONE, SHALL pulse rvalid[owner] for one cycle with rdata/err held stable, then return to IDLE.
REQ-019 SHALL keep rdata and err stable outside DONE until the next completion.
REQ-020 Timing with zero wait states: gnt in cycle T, mem_en in T+1, rvalid in T+2, next gnt no earlier than T+3.
REQ-021 Requesters SHALL hold req and fields until gnt; a req still high after rvalid SHALL be treated as a new request.
REQ-022 SHALL drive cpu_stall = req[0] & ~rvalid[0], combinationally.
REQ-023 SHALL ignore req changes while in BUSY or DONE; there is no preemption.

Reset
REQ-024 While reset=0 (asynchronous), SHALL force the FSM to IDLE and drive gnt, rvalid, mem_en, mem_we, mem_addr, mem_wdata, mem_be, rdata, err and the timeout counter to 0.
REQ-025 On reset, SHALL set last_owner=1 so that port 0 wins the first contention.
REQ-026 Reset asserted mid-access SHALL abort the access with no rvalid pulse; mem_en SHALL drop without waiting for clk.

Configuration
REQ-027 The macro DM_ARB_RR_EN SHALL select the contention policy.
REQ-028 With DM_ARB_RR_EN defined, when both ports request, SHALL grant the port != last_owner; last_owner SHALL update on every grant.
REQ-029 Without DM_ARB_RR_EN defined, port 0 SHALL always win contention, and last_owner SHALL be absent or unused.
REQ-030 Single-port requests SHALL be granted immediately under either policy.

Verification
REQ-031 CPU read of addr 0x10, be=4'hF, mem_ready high in first BUSY cycle, mem_rdata=0xDEADBEEF -> gnt[0] at T, rvalid[0] at T+2, rdata=0xDEADBEEF, err=0.
REQ-032 Both ports request continuously with DM_ARB_RR_EN defined -> grant sequence 0,1,0,1; without the macro -> 0,0,0,0.
REQ-033 mem_ready held low, TIMEOUT=3 -> mem_en for exactly 3 cycles, then rvalid with err=1 and rdata=0.
REQ-034 DMA write with be=4'h0 -> gnt[1], rvalid[1] one cycle later, mem_en never asserted.
REQ-035 reset pulled low during BUSY -> mem_en=0 immediately, no rvalid; after release, a pending req[0] is granted in the first IDLE cycle.
REQ-036 CPU write 0x12345678 with be=4'h3 -> mem_we=1, mem_be=4'h3, mem_wdata=0x12345678; cpu_stall high until and including the cycle before rvalid[0].
